// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   - FSM state encoding for the transmitter (PARITY exists only when
//     UART_TX_PARITY_EN is defined)
//   - frame constants (data width, line levels)
//   - symbol_edge_time(): clock cycles per bit, also used by the receiver
// Optional feature macro: UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;
`endif

  // Cycles per serial bit; integer divide, remainder is dropped.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO buffering bytes for the UART transmitter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, data_i  write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   data_o          head entry, valid while empty_o is low
//   count_o         number of stored entries
//   full_o, empty_o derived from count_o
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Transmit half of the memory-mapped UART. Bytes arrive over a valid/ready
// handshake, are buffered in uart_tx_fifo and serialized as 8N1 frames
// (8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   data_in        byte to transmit
//   data_in_valid  data_in offered this cycle
//   data_in_ready  FIFO has room (combinational from the registered count)
//   tx_busy        frame in progress or bytes pending (registered)
//   fifo_count     bytes buffered, excluding the byte being shifted
//   serial_out     TX line, idle high, driven from a flop
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit)
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to become non-empty
// START  | start bit (low) for one symbol time
// DATA   | data bits 0..7, LSB first, one symbol time each
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte on its last cycle if present
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          serial_out
);

  localparam int SYM_CYCLES = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W      = $clog2(SYM_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(SYM_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             serial_q;
  logic             busy_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic [7:0] fifo_head;
  logic       fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic       sym_last;

  assign sym_last      = (cyc_q == CYC_LAST);
  assign cyc_d         = sym_last ? '0 : cyc_q + CNT_W'(1);
  assign data_in_ready = !fifo_full;
  assign fifo_push     = data_in_valid && data_in_ready;
  // Pop from IDLE, or on the last stop-bit cycle so frames run back to back.
  assign fifo_pop      = !fifo_empty &&
                         ((state_q == IDLE) || ((state_q == STOP) && sym_last));

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (data_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // tx_busy follows the FSM's next state. A non-empty FIFO never leaves the
  // FSM in IDLE (it pops on that same edge), so this also covers pending bytes
  // while keeping busy aligned with the frame on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cyc_q <= '0;
          if (fifo_pop) begin
            state_q  <= START;
            shift_q  <= fifo_head;
            serial_q <= START_LEVEL;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_head;
`endif
          end
        end

        START: begin
          cyc_q <= cyc_d;
          if (sym_last) begin
            state_q  <= DATA;
            bit_q    <= '0;
            serial_q <= shift_q[0];
          end
        end

        DATA: begin
          cyc_q <= cyc_d;
          if (sym_last) begin
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= PARITY;
              serial_q <= parity_q;
`else
              state_q  <= STOP;
              serial_q <= STOP_LEVEL;
`endif
            end else begin
              bit_q    <= bit_q + 3'd1;
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          cyc_q <= cyc_d;
          if (sym_last) begin
            state_q  <= STOP;
            serial_q <= STOP_LEVEL;
          end
        end
`endif

        STOP: begin
          cyc_q <= cyc_d;
          if (sym_last) begin
            if (fifo_pop) begin
              state_q  <= START;
              shift_q  <= fifo_head;
              serial_q <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifo_head;
`endif
            end else begin
              state_q  <= IDLE;
              serial_q <= IDLE_LEVEL;
              busy_q   <= 1'b0;
            end
          end
        end

        default: begin
          state_q  <= IDLE;
          cyc_q    <= '0;
          serial_q <= IDLE_LEVEL;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Drives uart_transmitter at 10 cycles per bit and compares every cycle with a
// frame-level reference: a byte queue plus a countdown of the frame on the
// line, from which the expected line level is read out by bit position.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int DEPTH      = 4;
  localparam int SYM        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN  = FRAME_BITS * SYM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       serial_out;

  uart_transmitter #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count),
    .serial_out    (serial_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;       // cycles left of the frame on the line, 0 = idle
  bit         last_acc = 1'b0;
  int         peak = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME_LEN - rem) / SYM;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    if (idx == FRAME_BITS - 1) return 1'b1;
    return ^cur;
  endfunction

  task automatic step();
    bit pop;
    @(posedge clk);
    last_acc = data_in_valid && (mq.size() != DEPTH);
    pop      = (mq.size() != 0) && (rem <= 1);
    if (rem > 0) rem--;
    if (pop) begin
      cur = mq.pop_front();
      rem = FRAME_LEN;
    end
    if (last_acc) mq.push_back(data_in);
    if (mq.size() > peak) peak = mq.size();
    #1;
    chk("serial_out", serial_out, exp_line());
    chk("tx_busy", tx_busy, rem != 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("data_in_ready", data_in_ready, mq.size() != DEPTH);
  endtask

  task automatic push1(input logic [7:0] b);
    data_in = b;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rem != 0 || mq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", rem + mq.size(), 0);
  endtask

  initial begin
    int busy_cnt;
    int idx;
    bit saw_full;
    bit hit;

    // reset values
    #12;
    chk("rst_serial", serial_out, 1);
    chk("rst_ready", data_in_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    step();

    // 1: single byte, busy length
    push1(8'hA5);
    chk("t1_start_not_yet", serial_out, 1);
    busy_cnt = 0;
    for (int i = 0; i < FRAME_LEN + 20; i++) begin
      step();
      if (tx_busy) busy_cnt++;
    end
    chk("t1_busy_cycles", busy_cnt, FRAME_LEN);

    // 2: three consecutive pushes, no gap between frames
    peak = 0;
    busy_cnt = 0;
    data_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 8'(i);
      step();
      if (tx_busy) busy_cnt++;
    end
    data_in_valid = 1'b0;
    for (int i = 0; i < 3 * FRAME_LEN + 20; i++) begin
      step();
      if (tx_busy) busy_cnt++;
    end
    chk("t2_busy_cycles", busy_cnt, 3 * FRAME_LEN);
    chk("t2_peak_count", peak, 2);

    // 3: hold valid with 0x10..0x17 until all are accepted
    idx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 1500 && idx < 8; c++) begin
      data_in = 8'(8'h10 + idx);
      data_in_valid = 1'b1;
      step();
      if (last_acc) idx++;
      if (!data_in_ready && fifo_count == 3'(DEPTH)) saw_full = 1'b1;
    end
    data_in_valid = 1'b0;
    chk("t3_accepted", idx, 8);
    chk("t3_full_seen", saw_full, 1);
    drain(10 * FRAME_LEN);

    // 4: push at count=1 on the stop-last-cycle pop edge
    push1(8'h3C);
    push1(8'h5A);
    hit = 1'b0;
    for (int i = 0; i < FRAME_LEN + 5 && !hit; i++) begin
      step();
      if (rem == 1) hit = 1'b1;
    end
    chk("t4_reached_stop_end", hit, 1);
    chk("t4_count_before", fifo_count, 1);
    push1(8'hC3);
    chk("t4_count_hold", fifo_count, 1);
    chk("t4_restart", serial_out, 0);
    drain(3 * FRAME_LEN);

    // 5: async reset during data bit 3 of 0xFF with a byte still queued
    push1(8'hFF);
    push1(8'h00);
    hit = 1'b0;
    for (int i = 0; i < FRAME_LEN && !hit; i++) begin
      step();
      if (rem != 0 && (FRAME_LEN - rem) / SYM == 4 && (FRAME_LEN - rem) % SYM == 3) hit = 1'b1;
    end
    chk("t5_reached_bit3", hit, 1);
    chk("t5_busy_before", tx_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_serial", serial_out, 1);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_busy", tx_busy, 0);
    chk("t5_rst_ready", data_in_ready, 1);
    mq.delete();
    rem = 0;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) step();

`ifdef UART_TX_PARITY_EN
    // 6: parity bit of 0x07 is 1
    push1(8'h07);
    for (int i = 0; i < FRAME_LEN + 10; i++) begin
      step();
      if (rem == FRAME_LEN - 9 * SYM - 5) chk("t6_parity", serial_out, 1);
    end
`endif

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      data_in = 8'($urandom);
      data_in_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    data_in_valid = 1'b0;
    drain(6 * FRAME_LEN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
